// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request/response and memory bus signals of the two-master data memory arbiter
interface mem_arbiter_if;
    logic        i_m0_req;
    logic [31:0] i_m0_addr;
    logic [31:0] i_m0_wdata;
    logic [3:0]  i_m0_bmask;
    logic        i_m0_wren;
    logic        i_m0_lock;
    logic        o_m0_gnt;
    logic        o_m0_rvalid;
    logic [31:0] o_m0_rdata;
    logic        o_m0_err;

    logic        i_m1_req;
    logic [31:0] i_m1_addr;
    logic [31:0] i_m1_wdata;
    logic [3:0]  i_m1_bmask;
    logic        i_m1_wren;
    logic        i_m1_lock;
    logic        o_m1_gnt;
    logic        o_m1_rvalid;
    logic [31:0] o_m1_rdata;
    logic        o_m1_err;

    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        o_mem_wren;
    logic [31:0] i_mem_rdata;

    modport slave (
        input  i_m0_req, i_m0_addr, i_m0_wdata, i_m0_bmask, i_m0_wren, i_m0_lock,
        output o_m0_gnt, o_m0_rvalid, o_m0_rdata, o_m0_err,
        input  i_m1_req, i_m1_addr, i_m1_wdata, i_m1_bmask, i_m1_wren, i_m1_lock,
        output o_m1_gnt, o_m1_rvalid, o_m1_rdata, o_m1_err,
        output o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren,
        input  i_mem_rdata
    );

    modport master (
        output i_m0_req, i_m0_addr, i_m0_wdata, i_m0_bmask, i_m0_wren, i_m0_lock,
        input  o_m0_gnt, o_m0_rvalid, o_m0_rdata, o_m0_err,
        output i_m1_req, i_m1_addr, i_m1_wdata, i_m1_bmask, i_m1_wren, i_m1_lock,
        input  o_m1_gnt, o_m1_rvalid, o_m1_rdata, o_m1_err,
        input  o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren,
        output i_mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master data memory arbiter with locking, lock timeout and range check
// Optional round-robin tie-break in IDLE when ARB_RR_EN is defined; fixed m0 > m1 priority otherwise.
module mem_arbiter #(
    parameter int MEM_SIZE     = 1024,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic         i_clk,
    input  logic         i_reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

    localparam logic [31:0] MEM_WORDS = 32'(MEM_SIZE);
    localparam logic [8:0]  TO_LAST   = 9'(LOCK_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        gnt0, gnt1, tie_m1;
    logic        own_req, own_lock;
    logic        in_range0, in_range1;

    logic        rvalid0_q, rvalid1_q, err0_q, err1_q;
    logic [31:0] rdata0_q, rdata1_q;

    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_bmask;
    logic        mem_wren;

    assign in_range0 = {2'b00, bus.i_m0_addr[31:2]} < MEM_WORDS;
    assign in_range1 = {2'b00, bus.i_m1_addr[31:2]} < MEM_WORDS;

`ifdef ARB_RR_EN
    logic rr_q;
    // On a tie the master that did not win last time goes first.
    assign tie_m1 = ~rr_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rr_q <= 1'b0;
        end else if (gnt0 || gnt1) begin
            rr_q <= gnt1;
        end
    end
`else
    assign tie_m1 = 1'b0;
`endif

    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        own_req  = (state_q == OWN1) ? bus.i_m1_req  : bus.i_m0_req;
        own_lock = (state_q == OWN1) ? bus.i_m1_lock : bus.i_m0_lock;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (bus.i_m0_req && bus.i_m1_req) begin
                    gnt0 = ~tie_m1;
                    gnt1 = tie_m1;
                end else begin
                    gnt0 = bus.i_m0_req;
                    gnt1 = bus.i_m1_req;
                end
                if (gnt0 && bus.i_m0_lock) begin
                    state_d = OWN0;
                end else if (gnt1 && bus.i_m1_lock) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                gnt0 = (state_q == OWN0) && own_req;
                gnt1 = (state_q == OWN1) && own_req;
                if (own_req) begin
                    cnt_d = 8'd0;
                    if (!own_lock) begin
                        state_d = IDLE;
                    end
                // Release as the count reaches LOCK_TIMEOUT-1, so the other master
                // gets its grant LOCK_TIMEOUT cycles after the last locked access.
                end else if (({1'b0, cnt_q} + 9'd1) >= TO_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_bmask = 4'd0;
        mem_wren  = 1'b0;
        if (gnt0) begin
            mem_addr  = bus.i_m0_addr;
            mem_wdata = bus.i_m0_wdata;
            mem_bmask = bus.i_m0_bmask;
            mem_wren  = bus.i_m0_wren && in_range0;
        end else if (gnt1) begin
            mem_addr  = bus.i_m1_addr;
            mem_wdata = bus.i_m1_wdata;
            mem_bmask = bus.i_m1_bmask;
            mem_wren  = bus.i_m1_wren && in_range1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= 32'd0;
            rdata1_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= gnt0;
            rvalid1_q <= gnt1;
            err0_q    <= gnt0 && !in_range0;
            err1_q    <= gnt1 && !in_range1;
            if (gnt0) begin
                rdata0_q <= (!bus.i_m0_wren && in_range0) ? bus.i_mem_rdata : 32'd0;
            end
            if (gnt1) begin
                rdata1_q <= (!bus.i_m1_wren && in_range1) ? bus.i_mem_rdata : 32'd0;
            end
        end
    end

    assign bus.o_m0_gnt    = gnt0;
    assign bus.o_m1_gnt    = gnt1;
    assign bus.o_m0_rvalid = rvalid0_q;
    assign bus.o_m1_rvalid = rvalid1_q;
    assign bus.o_m0_err    = err0_q;
    assign bus.o_m1_err    = err1_q;
    assign bus.o_m0_rdata  = rdata0_q;
    assign bus.o_m1_rdata  = rdata1_q;
    assign bus.o_mem_addr  = mem_addr;
    assign bus.o_mem_wdata = mem_wdata;
    assign bus.o_mem_bmask = mem_bmask;
    assign bus.o_mem_wren  = mem_wren;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter with a behavioural data memory
module tb_mem_arbiter;
    typedef struct {
        int          m;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    rsp_t exp_q[$];

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];

    mem_arbiter_if bus ();

    mem_arbiter #(.MEM_SIZE(1024), .LOCK_TIMEOUT(16)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.i_mem_rdata = mem[bus.o_mem_addr[11:2]];

    always @(posedge clk) begin
        if (bus.o_mem_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.o_mem_bmask[b]) mem[bus.o_mem_addr[11:2]][8*b +: 8] <= bus.o_mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int m, input logic req, input logic wren, input logic lock,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] bmask);
        if (m == 0) begin
            bus.i_m0_req = req; bus.i_m0_wren = wren; bus.i_m0_lock = lock;
            bus.i_m0_addr = addr; bus.i_m0_wdata = wdata; bus.i_m0_bmask = bmask;
        end else begin
            bus.i_m1_req = req; bus.i_m1_wren = wren; bus.i_m1_lock = lock;
            bus.i_m1_addr = addr; bus.i_m1_wdata = wdata; bus.i_m1_bmask = bmask;
        end
    endtask

    task automatic idle_all();
        set_m(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    // Reference for one accepted access: bus contents now, response next cycle.
    task automatic expect_access(input string tag, input int m, input logic wren, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] bmask, input logic push);
        rsp_t  e;
        logic  inr;
        inr     = (addr[31:2] < 30'd1024);
        e.m     = m;
        e.err   = !inr;
        e.rdata = (!wren && inr) ? ref_mem[addr[11:2]] : 32'd0;
        chk({tag, " mem_wren"},  {31'd0, bus.o_mem_wren}, {31'd0, wren && inr});
        chk({tag, " mem_addr"},  bus.o_mem_addr, addr);
        chk({tag, " mem_bmask"}, {28'd0, bus.o_mem_bmask}, {28'd0, bmask});
        if (wren) chk({tag, " mem_wdata"}, bus.o_mem_wdata, wdata);
        if (wren && inr) begin
            for (int b = 0; b < 4; b++) begin
                if (bmask[b]) ref_mem[addr[11:2]][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        if (push) exp_q.push_back(e);
    endtask

    // Inputs are already driven (posedge+1); check grants mid-cycle, responses after the edge.
    task automatic cyc(input string tag, input logic eg0, input logic eg1);
        rsp_t e;
        logic ev0, ev1;
        #4;
        chk({tag, " gnt0"}, {31'd0, bus.o_m0_gnt}, {31'd0, eg0});
        chk({tag, " gnt1"}, {31'd0, bus.o_m1_gnt}, {31'd0, eg1});
        if (eg0) begin
            expect_access(tag, 0, bus.i_m0_wren, bus.i_m0_addr, bus.i_m0_wdata, bus.i_m0_bmask, !rst);
        end else if (eg1) begin
            expect_access(tag, 1, bus.i_m1_wren, bus.i_m1_addr, bus.i_m1_wdata, bus.i_m1_bmask, !rst);
        end else begin
            chk({tag, " idle mem_wren"}, {31'd0, bus.o_mem_wren}, 32'd0);
            chk({tag, " idle mem_addr"}, bus.o_mem_addr, 32'd0);
        end
        @(posedge clk);
        #1;
        ev0 = 1'b0;
        ev1 = 1'b0;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            ev0 = (e.m == 0);
            ev1 = (e.m == 1);
            if (ev0) begin
                chk({tag, " rdata0"}, bus.o_m0_rdata, e.rdata);
                chk({tag, " err0"}, {31'd0, bus.o_m0_err}, {31'd0, e.err});
            end else begin
                chk({tag, " rdata1"}, bus.o_m1_rdata, e.rdata);
                chk({tag, " err1"}, {31'd0, bus.o_m1_err}, {31'd0, e.err});
            end
        end
        chk({tag, " rvalid0"}, {31'd0, bus.o_m0_rvalid}, {31'd0, ev0});
        chk({tag, " rvalid1"}, {31'd0, bus.o_m1_rvalid}, {31'd0, ev1});
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = {16'hC0DE, 16'(i)};
            ref_mem[i] = {16'hC0DE, 16'(i)};
        end
        rst = 1'b1;
        idle_all();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #3;
        chk("reset rvalid0", {31'd0, bus.o_m0_rvalid}, 32'd0);
        chk("reset rvalid1", {31'd0, bus.o_m1_rvalid}, 32'd0);
        chk("reset err0",    {31'd0, bus.o_m0_err}, 32'd0);
        chk("reset err1",    {31'd0, bus.o_m1_err}, 32'd0);
        chk("reset rdata0",  bus.o_m0_rdata, 32'd0);
        chk("reset rdata1",  bus.o_m1_rdata, 32'd0);
        chk("reset bmask",   {28'd0, bus.o_mem_bmask}, 32'd0);
        @(posedge clk);
        #1;

        // Byte-masked write then read-back
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'b0011);
        cyc("wr m0", 1'b1, 1'b0);
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'd0, 4'b1111);
        cyc("rd m0", 1'b1, 1'b0);
        idle_all();
        cyc("rd m0 resp", 1'b0, 1'b0);
        chk("word4 value", ref_mem[4], 32'hC0DEBEEF);

        // Contention for four cycles
        for (int k = 0; k < 4; k++) begin
            set_m(0, 1'b1, 1'b0, 1'b0, 32'h20 + 32'(4 * k), 32'd0, 4'hF);
            set_m(1, 1'b1, 1'b0, 1'b0, 32'h100 + 32'(4 * k), 32'd0, 4'hF);
`ifdef ARB_RR_EN
            cyc($sformatf("tie %0d", k), (k % 2) == 1, (k % 2) == 0);
`else
            cyc($sformatf("tie %0d", k), 1'b1, 1'b0);
`endif
        end
        idle_all();
        cyc("tie drain", 1'b0, 1'b0);

        // m1 lock holds off m0 until the unlocked access
        set_m(1, 1'b1, 1'b0, 1'b1, 32'h40, 32'd0, 4'hF);
        cyc("lock1 rd", 1'b0, 1'b1);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h44, 32'd0, 4'hF);
        cyc("own1 a", 1'b0, 1'b0);
        cyc("own1 b", 1'b0, 1'b0);
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h48, 32'h12345678, 4'hF);
        cyc("unlock1 wr", 1'b0, 1'b1);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        cyc("m0 after unlock", 1'b1, 1'b0);
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h48, 32'd0, 4'hF);
        cyc("m0 rd back", 1'b1, 1'b0);

        // Lock timeout: m1 granted 16 cycles after m0's locked access
        set_m(0, 1'b1, 1'b0, 1'b1, 32'h50, 32'd0, 4'hF);
        cyc("lock0 rd", 1'b1, 1'b0);
        set_m(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h54, 32'd0, 4'hF);
        for (int k = 1; k < 16; k++) cyc($sformatf("own0 wait %0d", k), 1'b0, 1'b0);
        cyc("timeout gnt1", 1'b0, 1'b1);
        idle_all();

        // Out-of-range accesses
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF);
        cyc("oor wr m1", 1'b0, 1'b1);
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'd0, 4'hF);
        cyc("word0 intact", 1'b0, 1'b1);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_m(0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'd0, 4'hF);
        cyc("oor rd m0", 1'b1, 1'b0);

        // Reset in OWN0 with a read in flight
        set_m(0, 1'b1, 1'b0, 1'b1, 32'h60, 32'd0, 4'hF);
        cyc("rst lock0", 1'b1, 1'b0);
        rst = 1'b1;
        cyc("rst inflight", 1'b1, 1'b0);
        rst = 1'b0;
        set_m(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h64, 32'd0, 4'hF);
        cyc("post rst m1", 1'b0, 1'b1);
        idle_all();
        cyc("final drain", 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
